// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB pipeline latch feeding a 2**ADDR_W-entry register file with two bypassed read ports.
// Latency: MEM write readable by bypass after the loading edge N, from the array after edge N+1; reads are combinational.
// Backpressure: stall holds the latch and the commit repeats harmlessly; flush inserts a bubble and overrides stall.
module wb_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o
);

  localparam int REG_NUM = 2**ADDR_W;

  // One pending write-back: destination, enable, data.
  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
  } wb_t;

  wb_t               wb_q;
  logic [DATA_W-1:0] regs [REG_NUM];

  // MEM/WB latch: flush clears to a bubble, otherwise stall holds, otherwise load from MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= '{wd: wd_i, wreg: wreg_i, wdata: wdata_i};
    end
  end

  // Commit the latched write into the array; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_q.wreg && (wb_q.wd != '0)) begin
      regs[wb_q.wd] <= wb_q.wdata;
    end
  end

  // Read port 1: zero under reset/disable/r0, else bypass the pending write, else the array.
  always_comb begin
    rdata1 = '0;
    if (!rst || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (wb_q.wreg && (wb_q.wd == raddr1)) begin
      rdata1 = wb_q.wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rdata2 = '0;
    if (!rst || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (wb_q.wreg && (wb_q.wd == raddr2)) begin
      rdata2 = wb_q.wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

  assign wb_wd_o    = wb_q.wd;
  assign wb_wreg_o  = wb_q.wreg;
  assign wb_wdata_o = wb_q.wdata;

endmodule
